// File: rtl/debug_cmd_bridge_pkg.sv
// Shared constants and FSM encoding for the UART-to-debug-unit command bridge.
package debug_cmd_bridge_pkg;

  // UART byte width (default for NB_BYTE) and command word geometry.
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;

  // Command word fields, shared with the debug unit.
  localparam int unsigned EN_BIT   = 31;
  localparam int unsigned OPC_MSB  = 22;
  localparam int unsigned OPC_LSB  = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StApply = 3'd2,
    StHold  = 3'd3,
    StSend  = 3'd4
  } bridge_state_e;

  // The bridge cannot take new rx bytes outside IDLE/RECV.
  function automatic logic state_is_busy(input bridge_state_e s);
    return (s == StApply) || (s == StHold) || (s == StSend);
  endfunction

endpackage

// File: rtl/debug_cmd_bridge_if.sv
// UART/debug-unit side signals of the bridge; directions named from the bridge's view.
interface debug_cmd_bridge_if #(
  parameter int unsigned NB_GPIO = debug_cmd_bridge_pkg::WORD_W,
  parameter int unsigned NB_BYTE = debug_cmd_bridge_pkg::BYTE_W
);
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_tx_ready;
  logic [NB_GPIO-1:0] i_gpio_resp;
  logic [NB_GPIO-1:0] o_gpio;
  logic               o_tx_valid;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_busy;
  logic               o_frame_err;
  logic               o_overrun;

  // Bridge side.
  modport master (
    input  i_rx_valid, i_rx_data, i_tx_ready, i_gpio_resp,
    output o_gpio, o_tx_valid, o_tx_data, o_busy, o_frame_err, o_overrun
  );

  // Environment side (UART + debug unit).
  modport slave (
    output i_rx_valid, i_rx_data, i_tx_ready, i_gpio_resp,
    input  o_gpio, o_tx_valid, o_tx_data, o_busy, o_frame_err, o_overrun
  );
endinterface

// File: rtl/word_tx_serializer.sv
// Loads one word and offers it as bytes, MSB first, on a valid/ready handshake.
module word_tx_serializer
  import debug_cmd_bridge_pkg::*;
#(
  parameter int unsigned NB_GPIO = WORD_W,
  parameter int unsigned NB_BYTE = BYTE_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               load,
  input  logic [NB_GPIO-1:0] word,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               last_accept
);

  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  logic [NB_GPIO-1:0] shift_q, shift_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               accept;

  assign accept      = valid_q && tx_ready;
  assign last_accept = accept && (idx_q == LastIdx);
  assign tx_valid    = valid_q;
  assign tx_data     = shift_q[NB_GPIO-1 -: NB_BYTE];

  // Next state: load restarts the word, each accepted byte shifts the next one up.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      shift_d = word;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q << NB_BYTE;
      idx_d   = idx_q + IdxW'(1);
      if (idx_q == LastIdx) begin
        valid_d = 1'b0;
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/debug_cmd_bridge.sv
// UART byte stream -> 32-bit debug command, then debug response -> 4 UART bytes.
module debug_cmd_bridge
  import debug_cmd_bridge_pkg::*;
#(
  parameter int unsigned NB_GPIO        = WORD_W,
  parameter int unsigned NB_BYTE        = BYTE_W,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clock,
  input  logic i_reset,
  debug_cmd_bridge_if.master bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
  // An idle cycle seen with this count makes the counter reach TIMEOUT_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  bridge_state_e      state_q, state_d;
  logic [NB_GPIO-1:0] frame_q, frame_d;
  logic [NB_GPIO-1:0] gpio_q, gpio_d;
  logic [IdxW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]    to_cnt_q, to_cnt_d;
  logic [NB_GPIO-1:0] rx_shift;
  logic               ser_load;
  logic               ser_valid;
  logic [NB_BYTE-1:0] ser_data;
  logic               ser_last;
  logic               frame_err;
  logic               overrun;

  assign rx_shift = {frame_q[NB_GPIO-NB_BYTE-1:0], bus.i_rx_data};

  // FSM next state, command word and pulse outputs.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    gpio_d     = '0;
    ser_load   = 1'b0;
    frame_err  = 1'b0;
    overrun    = 1'b0;
    case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (bus.i_rx_valid) begin
          frame_d    = NB_GPIO'(bus.i_rx_data);
          byte_cnt_d = IdxW'(1);
          state_d    = StRecv;
        end
      end
      StRecv: begin
        // A byte in the timeout cycle wins over the timeout.
        if (bus.i_rx_valid) begin
          frame_d  = rx_shift;
          to_cnt_d = '0;
          if (byte_cnt_q == LastIdx) begin
            gpio_d     = rx_shift;
            byte_cnt_d = '0;
            state_d    = StApply;
          end else begin
            byte_cnt_d = byte_cnt_q + IdxW'(1);
          end
        end else if (to_cnt_q == CntLast) begin
          frame_err  = 1'b1;
          frame_d    = '0;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = StIdle;
        end else if (to_cnt_q != CntMax) begin
          to_cnt_d = to_cnt_q + CntW'(1);
        end
      end
      StApply: begin
        overrun        = bus.i_rx_valid;
        // Keep the address visible with enable dropped for clear-type opcodes.
        gpio_d         = frame_q;
        gpio_d[EN_BIT] = 1'b0;
        state_d        = StHold;
      end
      StHold: begin
        overrun  = bus.i_rx_valid;
        ser_load = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        overrun = bus.i_rx_valid;
        if (ser_last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, frame, counters and command word registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      gpio_q     <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      gpio_q     <= gpio_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // The serializer's shift register doubles as the latched response word.
  word_tx_serializer #(
    .NB_GPIO (NB_GPIO),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .load        (ser_load),
    .word        (bus.i_gpio_resp),
    .tx_ready    (bus.i_tx_ready),
    .tx_valid    (ser_valid),
    .tx_data     (ser_data),
    .last_accept (ser_last)
  );

  assign bus.o_gpio      = gpio_q;
  assign bus.o_tx_valid  = ser_valid;
  assign bus.o_tx_data   = ser_data;
  assign bus.o_busy      = state_is_busy(state_q);
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = overrun;

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Scoreboard bench for debug_cmd_bridge: stimulus queues expectations, monitors compare.
module tb_debug_cmd_bridge;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  debug_cmd_bridge_if #(.NB_GPIO(32), .NB_BYTE(8)) bus ();

  debug_cmd_bridge #(
    .NB_GPIO        (32),
    .NB_BYTE        (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int frame_err_cnt = 0;
  int overrun_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_cmd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted tx byte must be the next expected response byte.
  always @(negedge clk) begin
    if (rst_n && bus.o_tx_valid && bus.i_tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected no byte", bus.o_tx_data);
      end else begin
        check("tx_byte", 32'(bus.o_tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  // A stalled byte must stay offered and unchanged.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 32'(bus.o_tx_valid), 32'd1);
        check("tx_hold_data", 32'(bus.o_tx_data), 32'(prev_data));
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  // Command word sequence: APPLY (busy rises), HOLD, then SEND with tx_valid.
  int          stage = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] cur_cmd = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stage     = 0;
      prev_busy = 1'b0;
    end else begin
      case (stage)
        1: begin
          check("hold_gpio", bus.o_gpio, cur_cmd & 32'h7FFF_FFFF);
          stage = 2;
        end
        2: begin
          check("send_gpio", bus.o_gpio, 32'h0);
          check("send_latency_valid", 32'(bus.o_tx_valid), 32'd1);
          stage = 0;
        end
        default: begin
          if (bus.o_busy && !prev_busy) begin
            if (exp_cmd.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL apply_unexpected: got 0x%08h expected no command", bus.o_gpio);
            end else begin
              cur_cmd = exp_cmd.pop_front();
              check("apply_gpio", bus.o_gpio, cur_cmd);
            end
            stage = 1;
          end else if (!bus.o_busy) begin
            check("idle_gpio", bus.o_gpio, 32'h0);
          end
        end
      endcase
      prev_busy = bus.o_busy;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_frame_err) frame_err_cnt++;
      if (bus.o_overrun) overrun_cnt++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gpio"}, bus.o_gpio, 32'h0);
    check({tag, "_tx"}, {bus.o_tx_valid, bus.o_tx_data}, 32'h0);
    check({tag, "_flags"}, {bus.o_busy, bus.o_frame_err, bus.o_overrun}, 32'h0);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
  endtask

  // gap = idle cycles inserted between byte 0 and byte 1.
  task automatic send_frame(input logic [31:0] cmd, input logic [31:0] resp, input int gap);
    exp_cmd.push_back(cmd);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(resp[i*8 +: 8]);
    bus.i_gpio_resp = resp;
    for (int i = 3; i >= 0; i--) begin
      if (i == 2 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send_byte(cmd[i*8 +: 8]);
    end
  endtask

  // Waits for the response to drain; scrambles i_gpio_resp once SEND is under way.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.o_tx_valid) bus.i_gpio_resp = 32'hDEAD_BEEF;
      if (!bus.o_busy && exp_tx.size() == 0) break;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_done: got busy after %0d cycles expected idle", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bus.i_rx_valid  = 1'b0;
    bus.i_rx_data   = '0;
    bus.i_tx_ready  = 1'b1;
    bus.i_gpio_resp = '0;
    #2 rst_n = 1'b0;
    #10;
    check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Enable-set command, then enable-clear command with a known response.
    send_frame(32'h800D_0000, 32'hA5C3_1E77, 0);
    wait_done("cmd_enable");
    send_frame(32'h001E_0000, 32'h0040_0010, 0);
    wait_done("cmd_read");

    // Transmitter back-pressure for 5 cycles in the middle of SEND.
    send_frame(32'h1234_5678, 32'hC0FF_EE11, 0);
    k = 0;
    while (k < 20 && exp_tx.size() > 3) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 bus.i_tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.i_tx_ready = 1'b1;
    wait_done("stall");

    // Two bytes then silence: frame error 16 cycles after the second byte.
    send_byte(8'h11);
    send_byte(8'h22);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.o_frame_err) break;
    end
    check("timeout_cycle", 32'(k), 32'd16);
    @(negedge clk);
    check("timeout_pulse_width", 32'(bus.o_frame_err), 32'd0);
    check("timeout_not_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk);
    #1;
    send_frame(32'h0A0B_0C0D, 32'h0102_0304, 0);
    wait_done("after_timeout");

    // Second byte lands exactly in the would-be timeout cycle: accepted.
    send_frame(32'h8122_3344, 32'h5566_7788, 15);
    wait_done("timeout_edge");

    // Rx byte during SEND is dropped with a one-cycle overrun pulse.
    send_frame(32'h0099_0001, 32'hCAFE_F00D, 0);
    k = 0;
    while (k < 20 && !bus.o_tx_valid) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'hEE;
    @(negedge clk);
    check("overrun_pulse", 32'(bus.o_overrun), 32'd1);
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    @(negedge clk);
    check("overrun_width", 32'(bus.o_overrun), 32'd0);
    wait_done("overrun");

    // Reset after the third byte aborts the frame immediately.
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(32'h8F15_0007, 32'h1357_9BDF, 0);
    wait_done("after_reset");

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("frame_err_count", 32'(frame_err_cnt), 32'd1);
    check("overrun_count", 32'(overrun_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/debug_cmd_bridge.md
DEBUG_CMD_BRIDGE -- requirements
Module: debug_cmd_bridge

Interface
REQ-001 Parameter NB_GPIO, default 32: command/response word width, fixed at 4 bytes.
REQ-002 Parameter NB_BYTE, default 8: UART byte width.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: idle cycles allowed between bytes of one frame.
REQ-004 i_clock  in  1  single clock; all logic on the rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 i_rx_valid  in  1  one-cycle strobe: UART receiver has a byte.
REQ-007 i_rx_data  in  NB_BYTE  received byte, valid with i_rx_valid.
REQ-008 i_tx_ready  in  1  UART transmitter can accept a byte this cycle.
REQ-009 i_gpio_resp  in  NB_GPIO  debug-unit response word (its o_gpio).
REQ-010 o_gpio  out  NB_GPIO  registered command word to the debug unit (its i_gpio): bit31 enable, bits 22:16 opcode, bits 15:0 data.
REQ-011 o_tx_valid  out  1  byte offered to the UART transmitter.
REQ-012 o_tx_data  out  NB_BYTE  byte offered, held stable while o_tx_valid=1 and i_tx_ready=0.
REQ-013 o_busy  out  1  high in every state except IDLE and RECV.
REQ-014 o_frame_err  out  1  one-cycle pulse when a partial frame is discarded on timeout.
REQ-015 o_overrun  out  1  one-cycle pulse when a byte arrives while o_busy=1; the byte is dropped.

Function
REQ-016 FSM states: IDLE, RECV, APPLY, HOLD, SEND.
REQ-017 IDLE: o_gpio=0; on i_rx_valid, shift in the byte, byte_cnt=1, go to RECV.
REQ-018 RECV: each i_rx_valid shifts in a byte, MSB first (frame = {b0,b1,b2,b3}); the 4th byte moves to APPLY on the next cycle.
REQ-019 APPLY: lasts exactly 1 cycle; o_gpio = frame exactly as received, including bit31.
REQ-020 HOLD: lasts exactly 1 cycle; o_gpio = frame with bit31 forced to 0, so clear-type opcodes still see their address; at the end of HOLD, latch i_gpio_resp into the response register.
REQ-021 SEND: o_gpio=0; offer the 4 response bytes MSB first; advance only on o_tx_valid&&i_tx_ready; after the 4th accepted byte, go to IDLE with o_tx_valid=0 in the next cycle.
REQ-022 Latency: first o_tx_valid is asserted 3 cycles after the cycle that accepted the 4th rx byte.
REQ-023 Timeout counter: cleared on every accepted byte; counts only in RECV.
REQ-024 Timeout: when the counter reaches TIMEOUT_CYCLES, discard the partial frame, pulse o_frame_err, and return to IDLE.
REQ-025 A byte arriving in the same cycle as the timeout is accepted; no timeout fires that cycle.
REQ-026 A byte arriving in APPLY, HOLD or SEND is dropped and pulses o_overrun; no state change.
REQ-027 Counter width is clog2(TIMEOUT_CYCLES+1) and the counter saturates, never wrapping; byte indices wrap mod 4 only through state exit.
REQ-028 Every command produces exactly one 4-byte response, including write-only opcodes (the response is whatever i_gpio_resp holds).

Reset
REQ-029 While i_reset=0, asynchronously: state=IDLE; o_gpio=0; o_tx_valid=0; o_tx_data=0; o_busy=0; o_frame_err=0; o_overrun=0; all counters and the frame/response registers =0.
REQ-030 Reset asserted mid-frame or mid-SEND aborts immediately; after release the bridge starts in IDLE with no residual bytes.

Structure
REQ-031 A shared package/header holds the FSM state encodings, NB_BYTE, BYTES_PER_WORD=4 and the opcode field positions (enable bit 31, opcode 22:16, data 15:0) shared with the debug unit.
REQ-032 One sub-module, word_tx_serializer: loads a 32-bit word and emits it as 4 bytes MSB first on a valid/ready handshake; the FSM in debug_cmd_bridge drives it.

Verification
REQ-033 Rx 0x80,0x0D,0x00,0x00 -> one APPLY cycle with o_gpio=0x800D0000, then HOLD with 0x000D0000, then o_gpio=0; 4 tx bytes equal to i_gpio_resp.
REQ-034 Rx 0x00,0x1E,0x00,0x00 with i_gpio_resp=0x00400010 at the end of HOLD -> tx bytes 0x00,0x40,0x00,0x10 in order.
REQ-035 i_tx_ready=0 for 5 cycles during SEND -> o_tx_data stable and o_tx_valid held; no byte skipped or duplicated.
REQ-036 TIMEOUT_CYCLES=16; rx 2 bytes then silence -> o_frame_err pulses once 16 cycles after the 2nd byte; the next 4-byte frame decodes correctly.
REQ-037 Rx byte during SEND -> o_overrun pulses 1 cycle and the response bytes are unchanged.
REQ-038 Assert i_reset after the 3rd rx byte -> all outputs 0 immediately; after release, frame 0x8F,0x15,0x00,0x07 -> APPLY o_gpio=0x8F150007.
